// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle processor control FSM: fetches an instruction word, sequences the
// register-file/ALU/G-latch enables over EXG/EXW, and retires it in ADV.
module proc_ctrl_fsm #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned OPC_W    = 4,
  localparam int unsigned INSTR_W = OPC_W + 2 * SEL_W
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                run_i,
  input  logic [INSTR_W-1:0]  instr_i,
  input  logic                instr_valid_i,
  output logic [ADDR_W-1:0]   addr_o,
  output logic                imm_en_o,
  output logic [NUM_REGS-1:0] bus1_en_o,
  output logic [NUM_REGS-1:0] bus2_en_o,
  output logic [NUM_REGS-1:0] reg_wr_en_o,
  output logic                g_in_o,
  output logic                g_out_o,
  output logic [6:0]          alu_op_o,
  output logic                done_o,
  output logic                illegal_o,
  output logic                halted_o
);

  localparam logic [OPC_W-1:0] OpNop  = 4'h0;
  localparam logic [OPC_W-1:0] OpLoad = 4'h1;
  localparam logic [OPC_W-1:0] OpMove = 4'h2;
  localparam logic [OPC_W-1:0] OpAdd  = 4'h3;
  localparam logic [OPC_W-1:0] OpSub  = 4'h4;
  localparam logic [OPC_W-1:0] OpXor  = 4'h5;
  localparam logic [OPC_W-1:0] OpOr   = 4'h6;
  localparam logic [OPC_W-1:0] OpAnd  = 4'h7;
  localparam logic [OPC_W-1:0] OpDiv  = 4'h8;
  localparam logic [OPC_W-1:0] OpMod  = 4'h9;
  localparam logic [OPC_W-1:0] OpHalt = 4'hF;

  localparam logic [NUM_REGS-1:0] OneHotBase = NUM_REGS'(1);

  typedef enum logic [2:0] {StFetch, StExg, StExw, StAdv, StHalt} state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic [OPC_W-1:0]   ir_opc, in_opc;
  logic [SEL_W-1:0]   ir_rx, ir_ry;
  logic [6:0]         alu_sel;
  logic               ir_is_alu, ir_is_illegal;

  assign ir_opc = ir_q[INSTR_W-1 -: OPC_W];
  assign ir_rx  = ir_q[2*SEL_W-1:SEL_W];
  assign ir_ry  = ir_q[SEL_W-1:0];
  assign in_opc = instr_i[INSTR_W-1 -: OPC_W];

  // alu_op bit order, MSB first: xor, add, sub, and, or, div, mod
  always_comb begin
    alu_sel   = 7'b0;
    ir_is_alu = 1'b1;
    unique case (ir_opc)
      OpXor:   alu_sel = 7'b1000000;
      OpAdd:   alu_sel = 7'b0100000;
      OpSub:   alu_sel = 7'b0010000;
      OpAnd:   alu_sel = 7'b0001000;
      OpOr:    alu_sel = 7'b0000100;
      OpDiv:   alu_sel = 7'b0000010;
      OpMod:   alu_sel = 7'b0000001;
      default: ir_is_alu = 1'b0;
    endcase
  end

  assign ir_is_illegal = (ir_opc >= 4'hA) && (ir_opc != OpHalt);

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    addr_d      = addr_q;
    imm_en_o    = 1'b0;
    bus1_en_o   = '0;
    bus2_en_o   = '0;
    reg_wr_en_o = '0;
    g_in_o      = 1'b0;
    g_out_o     = 1'b0;
    alu_op_o    = 7'b0;
    done_o      = 1'b0;
    illegal_o   = 1'b0;
    halted_o    = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (run_i && instr_valid_i) begin
          ir_d = instr_i;
          unique case (in_opc)
            OpAdd, OpSub, OpXor, OpOr, OpAnd, OpDiv, OpMod: state_d = StExg;
            OpLoad, OpMove: state_d = StExw;
            OpHalt:         state_d = StHalt;
            default:        state_d = StAdv;  // NOP and undefined opcodes
          endcase
        end
      end
      StExg: begin
        bus1_en_o = OneHotBase << ir_rx;
        bus2_en_o = OneHotBase << ir_ry;
        alu_op_o  = alu_sel;
        g_in_o    = 1'b1;
        state_d   = StExw;
      end
      StExw: begin
        reg_wr_en_o = OneHotBase << ir_rx;
        if (ir_is_alu) begin
          g_out_o  = 1'b1;
          alu_op_o = alu_sel;
        end else if (ir_opc == OpLoad) begin
          imm_en_o = 1'b1;
        end else begin
          bus1_en_o = OneHotBase << ir_ry;
        end
        state_d = StAdv;
      end
      StAdv: begin
        done_o    = 1'b1;
        illegal_o = ir_is_illegal;
        addr_d    = addr_q + ADDR_W'(1);
        state_d   = StFetch;
      end
      StHalt: begin
        halted_o = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StFetch;
      ir_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Self-checking bench for proc_ctrl_fsm: directed scenarios plus random stimulus,
// all compared against a per-instruction expected-cycle queue model.
module tb_proc_ctrl_fsm;

  typedef struct packed {
    logic [4:0] addr;
    logic       imm;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] wr;
    logic       gi;
    logic       go;
    logic [6:0] alu;
    logic       done;
    logic       ill;
    logic       halt;
  } out_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       instr_valid = 1'b0;
  logic [9:0] instr = '0;

  logic [4:0] addr;
  logic       imm_en, g_in, g_out, done, illegal, halted;
  logic [7:0] bus1_en, bus2_en, reg_wr_en;
  logic [6:0] alu_op;
  out_t       dut_w;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  out_t       exp_q[$];
  logic [4:0] m_addr = '0;
  bit         m_halt = 1'b0;

  always #5 clk = ~clk;

  proc_ctrl_fsm dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .run_i        (run),
    .instr_i      (instr),
    .instr_valid_i(instr_valid),
    .addr_o       (addr),
    .imm_en_o     (imm_en),
    .bus1_en_o    (bus1_en),
    .bus2_en_o    (bus2_en),
    .reg_wr_en_o  (reg_wr_en),
    .g_in_o       (g_in),
    .g_out_o      (g_out),
    .alu_op_o     (alu_op),
    .done_o       (done),
    .illegal_o    (illegal),
    .halted_o     (halted)
  );

  assign dut_w = {addr, imm_en, bus1_en, bus2_en, reg_wr_en, g_in, g_out, alu_op,
                  done, illegal, halted};

  task automatic check_eq(input string tag, input logic [41:0] got, input logic [41:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] alu_of(input logic [3:0] op);
    case (op)
      4'd5:    return 7'b1000000;  // xor
      4'd3:    return 7'b0100000;  // add
      4'd4:    return 7'b0010000;  // sub
      4'd7:    return 7'b0001000;  // and
      4'd6:    return 7'b0000100;  // or
      4'd8:    return 7'b0000010;  // div
      4'd9:    return 7'b0000001;  // mod
      default: return 7'b0;
    endcase
  endfunction

  // Queue up the expected outputs of every cycle the instruction occupies after accept.
  task automatic push_seq(input logic [9:0] ins);
    logic [3:0] op;
    logic [2:0] rx, ry;
    out_t e, adv;
    op = ins[9:6];
    rx = ins[5:3];
    ry = ins[2:0];
    adv = '0;
    adv.done = 1'b1;
    if (op >= 4'd3 && op <= 4'd9) begin
      e = '0; e.b1 = 8'(1) << rx; e.b2 = 8'(1) << ry; e.alu = alu_of(op); e.gi = 1'b1;
      exp_q.push_back(e);
      e = '0; e.go = 1'b1; e.wr = 8'(1) << rx; e.alu = alu_of(op);
      exp_q.push_back(e);
      exp_q.push_back(adv);
    end else if (op == 4'd1) begin
      e = '0; e.imm = 1'b1; e.wr = 8'(1) << rx;
      exp_q.push_back(e);
      exp_q.push_back(adv);
    end else if (op == 4'd2) begin
      e = '0; e.b1 = 8'(1) << ry; e.wr = 8'(1) << rx;
      exp_q.push_back(e);
      exp_q.push_back(adv);
    end else if (op == 4'd15) begin
      m_halt = 1'b1;
    end else begin
      adv.ill = (op >= 4'd10);
      exp_q.push_back(adv);
    end
  endtask

  task automatic model_edge(input bit rst, input bit r, input bit v, input logic [9:0] ins);
    out_t p;
    if (rst) begin
      exp_q.delete();
      m_addr = '0;
      m_halt = 1'b0;
    end else if (m_halt) begin
      // frozen until reset
    end else if (exp_q.size() != 0) begin
      p = exp_q.pop_front();
      if (p.done) m_addr = m_addr + 5'd1;
    end else if (r && v) begin
      push_seq(ins);
    end
  endtask

  function automatic out_t model_out();
    out_t e;
    e = '0;
    if (m_halt) e.halt = 1'b1;
    else if (exp_q.size() != 0) e = exp_q[0];
    e.addr = m_addr;
    return e;
  endfunction

  task automatic step(input bit rst, input bit r, input bit v, input logic [9:0] ins,
                      input string tag);
    reset = rst;
    run = r;
    instr_valid = v;
    instr = ins;
    @(posedge clk);
    #1;
    model_edge(rst, r, v, ins);
    check_eq(tag, dut_w, model_out());
  endtask

  // Accept an instruction, then run it to completion with junk on run/instr_valid.
  task automatic issue(input logic [9:0] ins, input string tag);
    step(1'b0, 1'b1, 1'b1, ins, tag);
    for (int i = 0; i < 6 && exp_q.size() != 0; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 10'($urandom), tag);
    step(1'b0, 1'b0, 1'b0, 10'd0, tag);
  endtask

  initial begin
    out_t e;
    step(1'b1, 1'b1, 1'b1, {4'd3, 6'd0}, "reset");
    check_eq("reset_zero", dut_w, 42'd0);

    for (int i = 0; i < 3; i++) issue(10'd0, "nop");
    // ADD r2,r5 at addr 3
    step(1'b0, 1'b1, 1'b1, {4'd3, 3'd2, 3'd5}, "add_acc");
    e = '0; e.addr = 5'd3; e.b1 = 8'h04; e.b2 = 8'h20; e.alu = 7'b0100000; e.gi = 1'b1;
    check_eq("add_exg", dut_w, e);
    step(1'b0, 1'b0, 1'b0, 10'd0, "add_exw");
    e = '0; e.addr = 5'd3; e.go = 1'b1; e.wr = 8'h04; e.alu = 7'b0100000;
    check_eq("add_exw_k", dut_w, e);
    step(1'b0, 1'b0, 1'b0, 10'd0, "add_adv");
    e = '0; e.addr = 5'd3; e.done = 1'b1;
    check_eq("add_adv_k", dut_w, e);
    step(1'b0, 1'b0, 1'b0, 10'd0, "add_post");
    check_eq("add_addr4", 42'(addr), 42'd4);

    // LOAD r7 ; MOVE r1,r7
    step(1'b0, 1'b1, 1'b1, {4'd1, 3'd7, 3'd0}, "load_acc");
    e = '0; e.addr = 5'd4; e.imm = 1'b1; e.wr = 8'h80;
    check_eq("load_exw", dut_w, e);
    step(1'b0, 1'b0, 1'b1, 10'd0, "load_adv");
    check_eq("load_done", 42'(done), 42'd1);
    step(1'b0, 1'b0, 1'b0, 10'd0, "load_post");
    step(1'b0, 1'b1, 1'b1, {4'd2, 3'd1, 3'd7}, "move_acc");
    e = '0; e.addr = 5'd5; e.b1 = 8'h80; e.wr = 8'h02;
    check_eq("move_exw", dut_w, e);
    step(1'b0, 1'b0, 1'b0, 10'd0, "move_adv");
    check_eq("move_done", 42'(done), 42'd1);
    step(1'b0, 1'b0, 1'b0, 10'd0, "move_post");
    issue({4'd2, 3'd3, 3'd3}, "move_same");

    for (int i = 0; i < 40 && m_addr != 5'd9; i++) issue(10'd0, "nop_to9");
    step(1'b0, 1'b1, 1'b1, {4'hC, 6'h2A}, "ill_acc");
    e = '0; e.addr = 5'd9; e.done = 1'b1; e.ill = 1'b1;
    check_eq("ill_adv", dut_w, e);
    step(1'b0, 1'b0, 1'b0, 10'd0, "ill_post");
    check_eq("ill_addr10", 42'(addr), 42'd10);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, {4'd3, 6'($urandom)}, "run_low");
    check_eq("run_low_addr", 42'(addr), 42'd10);

    for (int i = 0; i < 40 && m_addr != 5'd31; i++) issue(10'd0, "nop_to31");
    issue(10'd0, "nop_wrap");
    check_eq("wrap_addr0", 42'(addr), 42'd0);

    step(1'b0, 1'b1, 1'b1, {4'hF, 6'd0}, "halt_acc");
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 10'($urandom), "halt_hold");
    e = '0; e.halt = 1'b1;
    check_eq("halt_k", dut_w, e);
    step(1'b1, 1'b0, 1'b0, 10'd0, "halt_reset");
    check_eq("halt_cleared", dut_w, 42'd0);
    issue({4'd6, 3'd4, 3'd1}, "after_halt_or");

    step(1'b0, 1'b1, 1'b1, {4'd4, 3'd0, 3'd6}, "sub_acc");
    step(1'b1, 1'b1, 1'b1, {4'd3, 6'd9}, "sub_reset");
    check_eq("sub_abort_zero", dut_w, 42'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 10'd0, "sub_no_done");

    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 4) != 0), 10'($urandom), "random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/proc_ctrl_fsm.md
PROC_CTRL_FSM -- requirements
Module: proc_ctrl_fsm

Interface
REQ-001 Parameter NUM_REGS, default 8, is the register-file size; it SHALL be a power of two, 2..16.
REQ-002 Parameter SEL_W, default 3, is log2(NUM_REGS), the register-select width.
REQ-003 Parameter ADDR_W, default 5, is the program-counter width.
REQ-004 Parameter OPC_W, fixed at 4, is the opcode width; INSTR_W = OPC_W + 2*SEL_W.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 run  in  1  level enable; when 0, no new instruction is accepted.
REQ-008 instr  in  INSTR_W  instruction word: opcode [INSTR_W-1 -: 4], rx [2*SEL_W-1:SEL_W], ry [SEL_W-1:0].
REQ-009 instr_valid  in  1  instr is valid for the current addr.
REQ-010 addr  out  ADDR_W  program counter / instruction-memory address.
REQ-011 imm_en  out  1  drives the immediate data onto bus1.
REQ-012 bus1_en, bus2_en  out  NUM_REGS each  one-hot register-to-bus buffer enables.
REQ-013 reg_wr_en  out  NUM_REGS  one-hot register write enable.
REQ-014 g_in, g_out  out  1 each  G latch load / G drive onto bus1.
REQ-015 alu_op  out  7  one-hot {xor, add, sub, and, or, div, mod}.
REQ-016 done  out  1  one-cycle pulse at instruction retirement.
REQ-017 illegal  out  1  one-cycle pulse when an undefined opcode retires.
REQ-018 halted  out  1  level; high while in HALT.

Function
REQ-019 Opcodes SHALL be: 0000 NOP, 0001 LOAD, 0010 MOVE, 0011 ADD, 0100 SUB, 0101 XOR, 0110 OR, 0111 AND, 1000 DIV, 1001 MOD, 1111 HALT, 1010-1110 illegal.
REQ-020 The states SHALL be FETCH, EXG, EXW, ADV and HALT; every output is a Moore function of the state and the registered instruction (IR).
REQ-021 In FETCH, when run=1 and instr_valid=1, IR SHALL capture instr; otherwise the block holds FETCH with addr unchanged.
REQ-022 FETCH next state SHALL be: EXG for ALU ops; EXW for LOAD and MOVE; ADV for NOP and illegal opcodes; HALT for HALT.
REQ-023 EXG SHALL assert bus1_en=onehot(rx), bus2_en=onehot(ry), alu_op per opcode and g_in=1, then go to EXW.
REQ-024 EXW for ALU ops SHALL assert g_out=1, reg_wr_en=onehot(rx) and hold alu_op, then go to ADV.
REQ-025 EXW for LOAD SHALL assert imm_en=1 and reg_wr_en=onehot(rx); for MOVE it SHALL assert bus1_en=onehot(ry) and reg_wr_en=onehot(rx); then go to ADV.
REQ-026 ADV SHALL assert done=1, plus illegal=1 for an illegal opcode, set addr=addr+1 modulo 2^ADDR_W, then go to FETCH.
REQ-027 Latency from accept to done SHALL be 3 cycles for ALU ops, 2 cycles for LOAD and MOVE, and 1 cycle for NOP and illegal opcodes.
REQ-028 HALT SHALL hold halted=1 and all other outputs 0, with addr frozen, until reset.
REQ-029 In every state, any output not listed for that state SHALL be 0.
REQ-030 MOVE with rx=ry SHALL still execute; no hazard check is made.
REQ-031 run and instr_valid SHALL be ignored outside FETCH; deasserting them never aborts an instruction in flight.
REQ-032 At addr=2^ADDR_W-1, ADV SHALL wrap addr to 0 with no other side effect.

Reset
REQ-033 reset=1 at a rising edge SHALL force FETCH, addr=0 and IR=0, and every output to 0, regardless of the current state, including HALT and mid-instruction.
REQ-034 reset SHALL dominate run and instr_valid in the same cycle.
REQ-035 While reset is held, no instruction SHALL be accepted.

Verification
REQ-036 ADD r2,r5 accepted at addr 3 -> EXG: bus1_en=0x04, bus2_en=0x20, alu_op=0100000, g_in=1; EXW: g_out=1, reg_wr_en=0x04; ADV: done=1; addr becomes 4.
REQ-037 LOAD r7 followed by MOVE r1,r7 -> LOAD EXW: imm_en=1, reg_wr_en=0x80; MOVE EXW: bus1_en=0x80, reg_wr_en=0x02; two done pulses, each 2 cycles after its accept.
REQ-038 Opcode 1100 at addr 9 -> next cycle done=1 and illegal=1, all enables 0, addr becomes 10.
REQ-039 run=0 for 5 cycles with instr_valid=1 -> block stays in FETCH, addr constant, no enables; with ADDR_W=5 at addr 31, a NOP retires and addr becomes 0.
REQ-040 HALT -> halted=1 held for 10 cycles, addr frozen; reset pulse -> addr=0, halted=0, normal fetch resumes.
REQ-041 reset asserted in EXG of a SUB -> next cycle all outputs 0, addr=0, no done pulse for the aborted instruction.
